// File: rtl/draw_pkg.sv
// Shared screen geometry defaults and controller state encoding for the
// rectangle plotter and its raster counter.
package draw_pkg;

  localparam int SCREEN_W = 320;
  localparam int SCREEN_H = 240;
  localparam int COORD_W  = 9;
  localparam int COLOUR_W = 3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRAW   = 2'd1,
    FINISH = 2'd2
  } state_t;

endpackage

// File: rtl/raster_counter.sv
// Two-dimensional column/row walker: emits screen coordinates in raster order
// (x fastest) across a cols x rows box anchored at (x_start, y_start).
module raster_counter #(
  parameter int COORD_W = draw_pkg::COORD_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic               en,
  input  logic [COORD_W-1:0] x_start,
  input  logic [COORD_W-1:0] y_start,
  input  logic [COORD_W:0]   cols,
  input  logic [COORD_W:0]   rows,
  output logic [COORD_W-1:0] x,
  output logic [COORD_W-1:0] y,
  output logic               last
);

  logic [COORD_W-1:0] x_base;
  logic [COORD_W:0]   col;
  logic [COORD_W:0]   row;
  logic [COORD_W:0]   cols_m1;
  logic [COORD_W:0]   rows_m1;
  logic               col_end;
  logic               row_end;

  // The box size is stored minus one so the end test is a plain equality.
  assign col_end = (col == cols_m1);
  assign row_end = (row == rows_m1);
  assign last    = col_end && row_end;

  // NOTE: reset is synchronous, so it lives inside the clocked branch, and all
  // state updates use non-blocking assignments to avoid read/write races.
  always_ff @(posedge clk) begin
    if (reset) begin
      x       <= '0;
      y       <= '0;
      x_base  <= '0;
      col     <= '0;
      row     <= '0;
      cols_m1 <= '0;
      rows_m1 <= '0;
    end else if (load) begin
      x       <= x_start;
      y       <= y_start;
      x_base  <= x_start;
      col     <= '0;
      row     <= '0;
      cols_m1 <= cols - 1'b1;
      rows_m1 <= rows - 1'b1;
    end else if (en) begin
      if (col_end) begin
        col <= '0;
        x   <= x_base;
        if (!row_end) begin
          row <= row + 1'b1;
          y   <= y + 1'b1;
        end
      end else begin
        col <= col + 1'b1;
        x   <= x + 1'b1;
      end
    end
  end

endmodule

// File: rtl/rect_plotter.sv
// Filled-rectangle generator for a VGA frame-buffer adapter: clips the request
// to the screen and streams one pixel write per clock in raster order.
module rect_plotter #(
  parameter int SCREEN_W = draw_pkg::SCREEN_W,
  parameter int SCREEN_H = draw_pkg::SCREEN_H,
  parameter int COORD_W  = draw_pkg::COORD_W,
  parameter int COLOUR_W = draw_pkg::COLOUR_W
) (
  input  logic                CLOCK_50,
  input  logic                reset,
  input  logic                start,
  input  logic [COORD_W-1:0]  x0,
  input  logic [COORD_W-1:0]  y0,
  input  logic [COORD_W-1:0]  width,
  input  logic [COORD_W-1:0]  height,
  input  logic [COLOUR_W-1:0] colour_in,
  output logic                ready,
  output logic [COORD_W-1:0]  x,
  output logic [COORD_W-1:0]  y,
  output logic [COLOUR_W-1:0] colour,
  output logic                plot,
  output logic                done
);

  import draw_pkg::*;

  localparam int              EXT_W = COORD_W + 1;
  localparam logic [EXT_W-1:0] SCR_W = EXT_W'(SCREEN_W);
  localparam logic [EXT_W-1:0] SCR_H = EXT_W'(SCREEN_H);

  state_t           state;
  state_t           next_state;
  logic             accept;
  logic             area_zero;
  logic             last_pixel;
  logic             cnt_load;
  logic             cnt_en;
  logic [EXT_W-1:0] x0_ext;
  logic [EXT_W-1:0] y0_ext;
  logic [EXT_W-1:0] w_ext;
  logic [EXT_W-1:0] h_ext;
  logic [EXT_W-1:0] x_room;
  logic [EXT_W-1:0] y_room;
  logic [EXT_W-1:0] w_eff;
  logic [EXT_W-1:0] h_eff;

  // One extra bit keeps origin+size comparisons free of wrap-around.
  always_comb begin
    x0_ext = {1'b0, x0};
    y0_ext = {1'b0, y0};
    w_ext  = {1'b0, width};
    h_ext  = {1'b0, height};
    x_room = SCR_W - x0_ext;
    y_room = SCR_H - y0_ext;

    if (x0_ext >= SCR_W)     w_eff = '0;
    else if (w_ext < x_room) w_eff = w_ext;
    else                     w_eff = x_room;

    if (y0_ext >= SCR_H)     h_eff = '0;
    else if (h_ext < y_room) h_eff = h_ext;
    else                     h_eff = y_room;
  end

  assign accept    = (state == IDLE) && start;
  assign area_zero = (w_eff == '0) || (h_eff == '0);

  // A zero-area request never loads the counter or colour, so x/y/colour keep
  // showing the last pixel actually written.
  assign cnt_load  = accept && !area_zero;
  assign cnt_en    = (state == DRAW) && !last_pixel;

  // NOTE: every combinational output gets a default first, so no path through
  // the case statement can leave it unassigned and infer a latch.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (accept) next_state = area_zero ? FINISH : DRAW;
      DRAW:    if (last_pixel) next_state = FINISH;
      FINISH:  next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Status outputs are registered from the next state so they line up with
  // the counter's registered coordinates.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state  <= IDLE;
      ready  <= 1'b1;
      plot   <= 1'b0;
      done   <= 1'b0;
      colour <= '0;
    end else begin
      state <= next_state;
      ready <= (next_state == IDLE);
      plot  <= (next_state == DRAW);
      done  <= (next_state == FINISH);
      if (cnt_load) colour <= colour_in;
    end
  end

  raster_counter #(
    .COORD_W (COORD_W)
  ) u_raster (
    .clk     (CLOCK_50),
    .reset   (reset),
    .load    (cnt_load),
    .en      (cnt_en),
    .x_start (x0),
    .y_start (y0),
    .cols    (w_eff),
    .rows    (h_eff),
    .x       (x),
    .y       (y),
    .last    (last_pixel)
  );

endmodule

// File: tb/tb_rect_plotter.sv
// Directed bench for rect_plotter: a table of requests with hand-clipped sizes
// plus sequences for reset abort, ignored start and back-to-back requests.
module tb_rect_plotter;

  logic       CLOCK_50 = 1'b0;
  logic       reset;
  logic       start;
  logic [8:0] x0, y0, width, height;
  logic [2:0] colour_in;
  logic       ready;
  logic [8:0] x, y;
  logic [2:0] colour;
  logic       plot;
  logic       done;

  int checks   = 0;
  int failures = 0;
  int hold_x   = 0;
  int hold_y   = 0;
  int hold_c   = 0;

  typedef struct {
    int x0, y0, w, h, c;
    int exp_w, exp_h;
    bit poke;
  } vec_t;

  vec_t vecs [9];

  rect_plotter dut (
    .CLOCK_50  (CLOCK_50),
    .reset     (reset),
    .start     (start),
    .x0        (x0),
    .y0        (y0),
    .width     (width),
    .height    (height),
    .colour_in (colour_in),
    .ready     (ready),
    .x         (x),
    .y         (y),
    .colour    (colour),
    .plot      (plot),
    .done      (done)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  task automatic run_req(input vec_t v, input string name);
    int n, bad, cyc, exp_n, dones, plots;
    exp_n = v.exp_w * v.exp_h;
    cyc = 0;
    while (ready !== 1'b1 && cyc < 100) begin
      @(negedge CLOCK_50);
      cyc++;
    end
    check({name, "_ready"}, ready, 1);
    x0 = 9'(v.x0); y0 = 9'(v.y0); width = 9'(v.w); height = 9'(v.h);
    colour_in = 3'(v.c);
    start = 1'b1;
    @(negedge CLOCK_50);
    start = 1'b0;
    x0 = 9'd77; y0 = 9'd33; width = 9'd9; height = 9'd9; colour_in = ~3'(v.c);
    n = 0;
    bad = 0;
    while (plot === 1'b1 && n < exp_n + 4) begin
      if (v.poke && n == 1) begin
        start = 1'b1; x0 = 9'd0; y0 = 9'd0; width = 9'd50; height = 9'd50; colour_in = 3'd1;
      end else begin
        start = 1'b0;
      end
      if (v.exp_w == 0) bad++;
      else if (x !== 9'(v.x0 + n % v.exp_w) || y !== 9'(v.y0 + n / v.exp_w) || colour !== 3'(v.c))
        bad++;
      n++;
      @(negedge CLOCK_50);
    end
    start = 1'b0;
    check({name, "_pixel_errors"}, bad, 0);
    check({name, "_pixel_count"}, n, exp_n);
    check({name, "_done"}, done, 1);
    check({name, "_ready_in_finish"}, ready, 0);
    if (exp_n > 0) begin
      hold_x = v.x0 + v.exp_w - 1;
      hold_y = v.y0 + v.exp_h - 1;
      hold_c = v.c;
    end
    check({name, "_hold_x"}, x, hold_x);
    check({name, "_hold_y"}, y, hold_y);
    check({name, "_hold_colour"}, colour, hold_c);
    dones = 0;
    plots = 0;
    repeat (5) begin
      @(negedge CLOCK_50);
      dones += int'(done);
      plots += int'(plot);
    end
    check({name, "_extra_done"}, dones, 0);
    check({name, "_extra_plot"}, plots, 0);
    check({name, "_ready_after"}, ready, 1);
  endtask

  initial begin
    logic [2:0] pat [7];
    logic [2:0] exp_pat [7];
    int dones, plots;

    vecs[0] = '{10, 20, 3, 2, 4, 3, 2, 1'b0};
    vecs[1] = '{318, 238, 5, 5, 2, 2, 2, 1'b0};
    vecs[2] = '{5, 5, 0, 7, 3, 0, 7, 1'b0};
    vecs[3] = '{400, 10, 4, 4, 5, 0, 4, 1'b0};
    vecs[4] = '{100, 239, 3, 2, 6, 3, 1, 1'b0};
    vecs[5] = '{319, 0, 1, 1, 1, 1, 1, 1'b0};
    vecs[6] = '{10, 240, 5, 5, 7, 5, 0, 1'b0};
    vecs[7] = '{300, 50, 511, 2, 3, 20, 2, 1'b0};
    vecs[8] = '{0, 0, 320, 240, 7, 320, 240, 1'b0};

    reset = 1'b1; start = 1'b0;
    x0 = '0; y0 = '0; width = '0; height = '0; colour_in = '0;
    repeat (3) @(negedge CLOCK_50);
    check("rst_ready", ready, 1);
    check("rst_plot", plot, 0);
    check("rst_done", done, 0);
    check("rst_x", x, 0);
    check("rst_y", y, 0);
    check("rst_colour", colour, 0);
    reset = 1'b0;
    @(negedge CLOCK_50);

    for (int i = 0; i < 9; i++) run_req(vecs[i], $sformatf("vec%0d", i));

    // start pulsed mid-draw with other operands must be ignored
    run_req('{10, 20, 3, 2, 4, 3, 2, 1'b1}, "poke");

    // reset on the third pixel of a 4x4 request
    x0 = 9'd50; y0 = 9'd60; width = 9'd4; height = 9'd4; colour_in = 3'd5;
    start = 1'b1;
    @(negedge CLOCK_50);
    start = 1'b0;
    @(negedge CLOCK_50);
    @(negedge CLOCK_50);
    check("abort_third_pixel_x", x, 52);
    reset = 1'b1;
    @(negedge CLOCK_50);
    check("abort_plot", plot, 0);
    check("abort_done", done, 0);
    check("abort_ready", ready, 1);
    check("abort_x", x, 0);
    check("abort_colour", colour, 0);
    reset = 1'b0;
    hold_x = 0; hold_y = 0; hold_c = 0;
    dones = 0; plots = 0;
    repeat (10) begin
      @(negedge CLOCK_50);
      dones += int'(done);
      plots += int'(plot);
    end
    check("abort_late_done", dones, 0);
    check("abort_late_plot", plots, 0);
    run_req('{7, 8, 2, 2, 2, 2, 2, 1'b0}, "after_abort");

    // reset wins over start in the same cycle
    x0 = 9'd3; y0 = 9'd3; width = 9'd3; height = 9'd3; colour_in = 3'd6;
    start = 1'b1; reset = 1'b1;
    @(negedge CLOCK_50);
    start = 1'b0; reset = 1'b0;
    check("rst_vs_start_plot", plot, 0);
    check("rst_vs_start_ready", ready, 1);
    @(negedge CLOCK_50);
    check("rst_vs_start_idle", plot, 0);
    hold_x = 0; hold_y = 0; hold_c = 0;

    // start held high: back-to-back requests with one idle cycle between
    x0 = 9'd1; y0 = 9'd1; width = 9'd2; height = 9'd1; colour_in = 3'd6;
    start = 1'b1;
    @(negedge CLOCK_50);
    for (int i = 0; i < 7; i++) begin
      pat[i] = {plot, done, ready};
      @(negedge CLOCK_50);
    end
    start = 1'b0;
    exp_pat[0] = 3'b100; exp_pat[1] = 3'b100; exp_pat[2] = 3'b010;
    exp_pat[3] = 3'b001; exp_pat[4] = 3'b100; exp_pat[5] = 3'b100;
    exp_pat[6] = 3'b010;
    for (int i = 0; i < 7; i++) check($sformatf("held_start_cycle%0d", i), pat[i], exp_pat[i]);
    repeat (2) @(negedge CLOCK_50);
    check("held_start_hold_x", x, 2);
    check("held_start_ready", ready, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
